gpu_core_param: RTL and testbench

- Parametrised successor of the single-lane GPU core: loads a program of 16-bit instructions into an internal instruction buffer, then executes it against a 16-entry register file with DATA_W-bit lanes.
- Sits between the dispatcher (instruction stream, valid/ready) and the shared-memory arbiter (request/data-valid handshake).
- Adds what the first generation lacked: width/depth generics, explicit load/execute/mem-wait FSM, store/load distinction, branches and a HALT-terminated program.

---
 rtl/gpu_core_param_if.sv | 30 +++
 rtl/gpu_core_param.sv | 204 ++++++++++++++++++++
 tb/tb_gpu_core_param.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_core_param_if.sv
// gpu_core_param_if: handshake/bus bundle between the parametrised GPU core, its
// instruction dispatcher and the shared-memory arbiter.
//   val_ins / instruction / rtr        : dispatcher -> core instruction stream
//   val_data / mem_dat                 : arbiter -> core response (ack or load data)
//   mem_req / mem_we / addr / st data  : core -> arbiter request
// Modports: slave = core side, master = environment (dispatcher + arbiter) side.
interface gpu_core_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
);
    logic              val_ins;
    logic [15:0]       instruction;
    logic              rtr;
    logic              val_data;
    logic [DATA_W-1:0] mem_dat;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] addr_shared_memory;
    logic [DATA_W-1:0] mem_dat_st;

    modport slave (
        input  val_ins, instruction, val_data, mem_dat,
        output rtr, mem_req, mem_we, addr_shared_memory, mem_dat_st
    );

    modport master (
        output val_ins, instruction, val_data, mem_dat,
        input  rtr, mem_req, mem_we, addr_shared_memory, mem_dat_st
    );
endinterface

// File: rtl/gpu_core_param.sv
// gpu_core_param: single-lane GPU core. Loads a program of 16-bit instructions into an
// instruction buffer (LOAD), executes it one instruction per cycle against a 16-entry
// DATA_W-bit register file (EXEC), and stalls on shared-memory accesses (MEM_WAIT).
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : gpu_core_param_if.slave (instruction stream + memory request/response)
//   core_id  : CORE_ID[3:0], constant
//   ready    : idle, i.e. LOAD state with an empty buffer
module gpu_core_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned IBUF_DEPTH = 16,
    parameter int unsigned CORE_ID    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    gpu_core_param_if.slave        bus,
    output logic [3:0]             core_id,
    output logic                   ready
);
    localparam int unsigned IDX_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    // One extra bit so count and pc can hold IBUF_DEPTH itself.
    localparam int unsigned PC_W  = IDX_W + 1;

    localparam logic [3:0] OpLdi  = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpAnd  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpShl  = 4'd7;
    localparam logic [3:0] OpLd   = 4'd8;
    localparam logic [3:0] OpSt   = 4'd9;
    localparam logic [3:0] OpBnz  = 4'd10;
    localparam logic [3:0] OpCid  = 4'd11;
    localparam logic [3:0] OpMul  = 4'd12;
    localparam logic [3:0] OpHalt = 4'd15;

    typedef enum logic [1:0] {StLoad, StExec, StMemWait} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] st_dat_q, st_dat_d;
    logic [15:0]       ibuf_q [IBUF_DEPTH];
    logic              ibuf_we;

    logic [15:0]       instr;
    logic [3:0]        op, rd, ra, rb;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] va, vb, vd;
    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   br_tgt;

    assign core_id  = 4'(CORE_ID);

    assign instr    = ibuf_q[pc_q[IDX_W-1:0]];
    assign op       = instr[15:12];
    assign rd       = instr[11:8];
    assign ra       = instr[7:4];
    assign rb       = instr[3:0];
    assign imm8     = instr[7:0];
    assign va       = rf_q[ra];
    assign vb       = rf_q[rb];
    assign vd       = rf_q[rd];
    assign pc_inc   = pc_q + PC_W'(1);
    assign br_tgt   = PC_W'(imm8[IDX_W-1:0]);

    assign bus.rtr                = (state_q == StLoad);
    assign ready                  = (state_q == StLoad) && (cnt_q == '0);
    assign bus.mem_req            = mem_req_q;
    assign bus.mem_we             = mem_we_q;
    assign bus.addr_shared_memory = addr_q;
    assign bus.mem_dat_st         = st_dat_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        rf_d     = rf_q;
        mem_req_d = mem_req_q;
        mem_we_d = mem_we_q;
        addr_d   = addr_q;
        st_dat_d = st_dat_q;
        ibuf_we  = 1'b0;
        wr_en    = 1'b0;
        wr_val   = '0;

        case (state_q)
            StLoad: begin
                if (bus.val_ins) begin
                    ibuf_we = 1'b1;
                    cnt_d   = cnt_q + PC_W'(1);
                    if (bus.instruction[15:12] == OpHalt ||
                        cnt_q == PC_W'(IBUF_DEPTH - 1)) begin
                        state_d = StExec;
                        pc_d    = '0;
                    end
                end
            end

            StExec: begin
                if (pc_q >= cnt_q) begin
                    // Ran off the end of the program (sequentially or via a branch).
                    state_d = StLoad;
                    cnt_d   = '0;
                    pc_d    = '0;
                end else begin
                    pc_d = pc_inc;
                    case (op)
                        OpLdi: begin wr_en = 1'b1; wr_val = DATA_W'(imm8); end
                        OpAdd: begin wr_en = 1'b1; wr_val = va + vb; end
                        OpSub: begin wr_en = 1'b1; wr_val = va - vb; end
                        OpAnd: begin wr_en = 1'b1; wr_val = va & vb; end
                        OpOr:  begin wr_en = 1'b1; wr_val = va | vb; end
                        OpXor: begin wr_en = 1'b1; wr_val = va ^ vb; end
                        // Shifting by >= DATA_W naturally yields zero.
                        OpShl: begin wr_en = 1'b1; wr_val = va << rb; end
                        OpCid: begin wr_en = 1'b1; wr_val = DATA_W'(CORE_ID); end
                        OpMul: begin wr_en = 1'b1; wr_val = va * vb; end
                        OpLd, OpSt: begin
                            pc_d      = pc_q;
                            mem_req_d = 1'b1;
                            mem_we_d  = (op == OpSt);
                            addr_d    = ADDR_W'(va) + ADDR_W'(rb);
                            if (op == OpSt) begin
                                st_dat_d = vd;
                            end
                            state_d = StMemWait;
                        end
                        OpBnz: begin
                            if (vd != '0) begin
                                pc_d = br_tgt;
                            end
                        end
                        OpHalt: begin
                            state_d = StLoad;
                            cnt_d   = '0;
                            pc_d    = '0;
                        end
                        default: ;
                    endcase
                end
            end

            StMemWait: begin
                if (bus.val_data) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        wr_en  = 1'b1;
                        wr_val = bus.mem_dat;
                    end
                    pc_d    = pc_inc;
                    state_d = StExec;
                end
            end

            default: state_d = StLoad;
        endcase

        if (wr_en) begin
            rf_d[rd] = wr_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            pc_q      <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            st_dat_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            st_dat_q  <= st_dat_d;
            rf_q      <= rf_d;
        end
    end

    // Buffer contents beyond the loaded count are never executed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (ibuf_we) begin
            ibuf_q[cnt_q[IDX_W-1:0]] <= bus.instruction;
        end
    end
endmodule

// File: tb/tb_gpu_core_param.sv
// tb_gpu_core_param: directed self-checking bench for gpu_core_param. Registers are
// observed by loading probe programs of stores and capturing the memory requests.
module tb_gpu_core_param;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gpu_core_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    gpu_core_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();
    logic [3:0] core_id, core_id4;
    logic       ready, ready4;

    gpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .IBUF_DEPTH(16), .CORE_ID(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .core_id (core_id),
        .ready   (ready)
    );

    gpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .IBUF_DEPTH(4), .CORE_ID(0)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus4.slave),
        .core_id (core_id4),
        .ready   (ready4)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0]   prog [$];
    logic [AW-1:0] rec_addr [64];
    logic          rec_we   [64];
    logic [DW-1:0] rec_dat  [64];
    int            rec_hold [64];
    int            rec_n;
    int            cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        int guard;
        foreach (prog[i]) begin
            bus.val_ins     = 1'b1;
            bus.instruction = prog[i];
            guard = 0;
            while (!bus.rtr && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check_eq("load_rtr_timeout", 32'd0, 32'd1);
            tick();
        end
        bus.val_ins = 1'b0;
    endtask

    // Runs until ready, answering each memory request after `delay` cycles of mem_req.
    task automatic run_prog(input int delay, input logic [DW-1:0] rdata, output int cycles);
        int wait_cnt;
        cycles   = 0;
        wait_cnt = 0;
        rec_n    = 0;
        while (!ready && cycles < 2000) begin
            if (bus.mem_req) begin
                if (wait_cnt == delay) begin
                    rec_addr[rec_n] = bus.addr_shared_memory;
                    rec_we[rec_n]   = bus.mem_we;
                    rec_dat[rec_n]  = bus.mem_dat_st;
                    rec_hold[rec_n] = wait_cnt;
                    rec_n++;
                    bus.val_data = 1'b1;
                    bus.mem_dat  = rdata;
                end else begin
                    wait_cnt++;
                end
            end
            tick();
            cycles++;
            if (bus.val_data) begin
                bus.val_data = 1'b0;
                wait_cnt     = 0;
                check_eq("mem_req_drop", 32'(bus.mem_req), 32'd0);
            end
        end
        check_eq("run_terminates", 32'(ready), 32'd1);
    endtask

    // Stores each listed register to address = its slot index, then HALT.
    task automatic probe(input logic [3:0] regs [$]);
        prog = {};
        foreach (regs[i]) prog.push_back({4'h9, regs[i], 4'h0, 4'(i)});
        prog.push_back(16'hF000);
        load_prog();
        run_prog(0, '0, cyc);
    endtask

    initial begin
        logic [3:0] rl [$];
        int guard;
        bus.val_ins = 0; bus.instruction = 0; bus.val_data = 0; bus.mem_dat = 0;
        bus4.val_ins = 0; bus4.instruction = 0; bus4.val_data = 0; bus4.mem_dat = 0;

        repeat (3) tick();
        check_eq("rst_rtr", 32'(bus.rtr), 32'd1);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("core_id", 32'(core_id), 32'd5);
        reset = 1'b1;
        tick();

        // Reset mid memory wait.
        prog = '{16'h1105, 16'h9101, 16'hF000};
        load_prog();
        guard = 0;
        while (!bus.mem_req && guard < 20) begin tick(); guard++; end
        check_eq("t1_req", 32'(bus.mem_req), 32'd1);
        check_eq("t1_addr", 32'(bus.addr_shared_memory), 32'h001);
        check_eq("t1_we", 32'(bus.mem_we), 32'd1);
        check_eq("t1_dat", 32'(bus.mem_dat_st), 32'h05);
        #2 reset = 1'b0;
        #1;
        check_eq("t1_async_req", 32'(bus.mem_req), 32'd0);
        check_eq("t1_async_addr", 32'(bus.addr_shared_memory), 32'd0);
        check_eq("t1_async_we", 32'(bus.mem_we), 32'd0);
        check_eq("t1_async_dat", 32'(bus.mem_dat_st), 32'd0);
        check_eq("t1_async_rtr", 32'(bus.rtr), 32'd1);
        check_eq("t1_async_ready", 32'(ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check_eq("t1_rtr", 32'(bus.rtr), 32'd1);
        check_eq("t1_ready", 32'(ready), 32'd1);
        rl = {};
        for (int r = 1; r < 16; r++) rl.push_back(4'(r));
        probe(rl);
        check_eq("t1_probe_n", 32'(rec_n), 32'd15);
        for (int r = 1; r < 16; r++) begin
            check_eq($sformatf("t1_r%0d_addr", r), 32'(rec_addr[r-1]), 32'(r - 1));
            check_eq($sformatf("t1_r%0d", r), 32'(rec_dat[r-1]), 32'd0);
        end

        // Basic ALU and timing.
        prog = '{16'h1112, 16'h1218, 16'h2312, 16'h3421, 16'hF000};
        load_prog();
        check_eq("t2_rtr_low", 32'(bus.rtr), 32'd0);
        run_prog(0, '0, cyc);
        check_eq("t2_exec_cycles", 32'(cyc), 32'd5);
        probe('{4'd3, 4'd4});
        check_eq("t2_r3", 32'(rec_dat[0]), 32'h2A);
        check_eq("t2_r4", 32'(rec_dat[1]), 32'h06);

        // Wrap-around, MUL, oversized shift, CID.
        prog = '{16'h11FF, 16'h1202, 16'h2312, 16'hC411, 16'h7519, 16'hB600, 16'hF000};
        load_prog();
        run_prog(0, '0, cyc);
        probe('{4'd3, 4'd4, 4'd5, 4'd6});
        check_eq("t3_add_wrap", 32'(rec_dat[0]), 32'h01);
        check_eq("t3_mul", 32'(rec_dat[1]), 32'h01);
        check_eq("t3_shl9", 32'(rec_dat[2]), 32'h00);
        check_eq("t3_cid", 32'(rec_dat[3]), 32'h05);

        // Stray val_data while idle, then a long-latency load.
        bus.val_data = 1'b1;
        bus.mem_dat  = 8'h55;
        tick();
        bus.val_data = 1'b0;
        check_eq("t4_stray_req", 32'(bus.mem_req), 32'd0);
        check_eq("t4_stray_ready", 32'(ready), 32'd1);
        prog = '{16'h1110, 16'h8213, 16'hF000};
        load_prog();
        run_prog(200, 8'h07, cyc);
        check_eq("t4_n", 32'(rec_n), 32'd1);
        check_eq("t4_addr", 32'(rec_addr[0]), 32'h013);
        check_eq("t4_we", 32'(rec_we[0]), 32'd0);
        check_eq("t4_hold", 32'(rec_hold[0]), 32'd200);
        probe('{4'd2});
        check_eq("t4_r2", 32'(rec_dat[0]), 32'h07);

        // Countdown loop with BNZ, then one store.
        prog = '{16'h1103, 16'h1201, 16'h3112, 16'hA102, 16'h9105, 16'hF000};
        load_prog();
        run_prog(0, '0, cyc);
        check_eq("t5_cycles", 32'(cyc), 32'd11);
        check_eq("t5_n", 32'(rec_n), 32'd1);
        check_eq("t5_addr", 32'(rec_addr[0]), 32'h005);
        check_eq("t5_we", 32'(rec_we[0]), 32'd1);
        check_eq("t5_dat", 32'(rec_dat[0]), 32'h00);

        // Full-buffer load on the depth-4 core, 5th word dropped.
        bus4.val_ins = 1'b1;
        prog = '{16'h1101, 16'h2211, 16'h0000, 16'h0000};
        foreach (prog[i]) begin
            bus4.instruction = prog[i];
            check_eq($sformatf("t6_rtr_w%0d", i), 32'(bus4.rtr), 32'd1);
            tick();
        end
        bus4.instruction = 16'h9105;
        check_eq("t6_rtr_full", 32'(bus4.rtr), 32'd0);
        check_eq("t6_busy", 32'(ready4), 32'd0);
        cyc = 0;
        while (!ready4 && cyc < 50) begin
            tick();
            cyc++;
            if (bus4.mem_req) check_eq("t6_no_req", 32'(bus4.mem_req), 32'd0);
        end
        bus4.val_ins = 1'b0;
        check_eq("t6_cycles", 32'(cyc), 32'd5);
        check_eq("t6_rtr_back", 32'(bus4.rtr), 32'd1);
        tick();
        check_eq("t6_idle", 32'(ready4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
